// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: operand forwarding from EX/MEM and MEM/WB,
// load-use bubble insertion, downstream stall and flush handling.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   output logic        id_ready,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   input  logic [31:0] id_rs1_data,
   input  logic [31:0] id_rs2_data,
   input  logic [31:0] id_imm,
   input  logic        id_alu_src,
   input  logic [3:0]  id_alu_control,
   input  logic [4:0]  id_rd_addr,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        id_mem_write,
   input  logic        flush,
   input  logic        ex_ready,
   input  logic [4:0]  exm_rd,
   input  logic        exm_reg_write,
   input  logic [31:0] exm_result,
   input  logic [4:0]  mwb_rd,
   input  logic        mwb_reg_write,
   input  logic [31:0] mwb_data,
   output logic        ex_valid,
   output logic [31:0] ex_in1,
   output logic [31:0] ex_in2,
   output logic [3:0]  ex_alu_control,
   output logic [31:0] ex_store_data,
   output logic [4:0]  ex_rd_addr,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write
);

   logic        r_valid;
   logic [4:0]  r_rs1_addr;
   logic [4:0]  r_rs2_addr;
   logic [31:0] r_rs1_data;
   logic [31:0] r_rs2_data;
   logic [31:0] r_imm;
   logic        r_alu_src;
   logic [3:0]  r_alu_control;
   logic [4:0]  r_rd;
   logic        r_reg_write;
   logic        r_mem_read;
   logic        r_mem_write;

   logic [31:0] w_fwd_rs1;
   logic [31:0] w_fwd_rs2;
   logic        w_load_use;
   logic        w_hold;
   logic        w_id_ready;

   // EX/MEM beats MEM/WB; x0 is never forwarded
   always_comb begin
      w_fwd_rs1 = r_rs1_data;
      if (exm_reg_write && (exm_rd != 5'd0) && (exm_rd == r_rs1_addr))
         w_fwd_rs1 = exm_result;
      else if (mwb_reg_write && (mwb_rd != 5'd0) && (mwb_rd == r_rs1_addr))
         w_fwd_rs1 = mwb_data;
   end

   always_comb begin
      w_fwd_rs2 = r_rs2_data;
      if (exm_reg_write && (exm_rd != 5'd0) && (exm_rd == r_rs2_addr))
         w_fwd_rs2 = exm_result;
      else if (mwb_reg_write && (mwb_rd != 5'd0) && (mwb_rd == r_rs2_addr))
         w_fwd_rs2 = mwb_data;
   end

   assign w_load_use = r_valid && r_mem_read && (r_rd != 5'd0) &&
                       ((r_rd == id_rs1_addr) || (r_rd == id_rs2_addr));
   assign w_hold     = r_valid && !ex_ready;
   assign w_id_ready = (!r_valid || ex_ready) && !w_load_use && !flush;

   // During a hold the forwarded operands are captured so they outlive their producers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid       <= 1'b0;
         r_rs1_addr    <= '0;
         r_rs2_addr    <= '0;
         r_rs1_data    <= '0;
         r_rs2_data    <= '0;
         r_imm         <= '0;
         r_alu_src     <= 1'b0;
         r_alu_control <= '0;
         r_rd          <= '0;
         r_reg_write   <= 1'b0;
         r_mem_read    <= 1'b0;
         r_mem_write   <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_hold) begin
         r_rs1_data <= w_fwd_rs1;
         r_rs2_data <= w_fwd_rs2;
      end else if (w_load_use) begin
         r_valid <= 1'b0;
      end else if (id_valid && w_id_ready) begin
         r_valid       <= 1'b1;
         r_rs1_addr    <= id_rs1_addr;
         r_rs2_addr    <= id_rs2_addr;
         r_rs1_data    <= id_rs1_data;
         r_rs2_data    <= id_rs2_data;
         r_imm         <= id_imm;
         r_alu_src     <= id_alu_src;
         r_alu_control <= id_alu_control;
         r_rd          <= id_rd_addr;
         r_reg_write   <= id_reg_write;
         r_mem_read    <= id_mem_read;
         r_mem_write   <= id_mem_write;
      end else begin
         r_valid <= 1'b0;
      end
   end

   assign id_ready       = w_id_ready;
   assign ex_valid       = r_valid;
   assign ex_in1         = w_fwd_rs1;
   assign ex_in2         = r_alu_src ? r_imm : w_fwd_rs2;
   assign ex_store_data  = w_fwd_rs2;
   assign ex_alu_control = r_alu_control;
   assign ex_rd_addr     = r_rd;
   assign ex_reg_write   = r_valid & r_reg_write;
   assign ex_mem_read    = r_valid & r_mem_read;
   assign ex_mem_write   = r_valid & r_mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, load-use bubble,
// stall with forward capture, flush during hold, immediate select, reset mid-stall.
module tb_id_ex_stage;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic        id_ready;
   logic [4:0]  id_rs1_addr;
   logic [4:0]  id_rs2_addr;
   logic [31:0] id_rs1_data;
   logic [31:0] id_rs2_data;
   logic [31:0] id_imm;
   logic        id_alu_src;
   logic [3:0]  id_alu_control;
   logic [4:0]  id_rd_addr;
   logic        id_reg_write;
   logic        id_mem_read;
   logic        id_mem_write;
   logic        flush;
   logic        ex_ready;
   logic [4:0]  exm_rd;
   logic        exm_reg_write;
   logic [31:0] exm_result;
   logic [4:0]  mwb_rd;
   logic        mwb_reg_write;
   logic [31:0] mwb_data;
   logic        ex_valid;
   logic [31:0] ex_in1;
   logic [31:0] ex_in2;
   logic [3:0]  ex_alu_control;
   logic [31:0] ex_store_data;
   logic [4:0]  ex_rd_addr;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;

   int unsigned n_vec;
   int unsigned n_err;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_alu_src(id_alu_src), .id_alu_control(id_alu_control),
      .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .flush(flush), .ex_ready(ex_ready),
      .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
      .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_data(mwb_data),
      .ex_valid(ex_valid), .ex_in1(ex_in1), .ex_in2(ex_in2),
      .ex_alu_control(ex_alu_control), .ex_store_data(ex_store_data),
      .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2,
                          input logic [31:0] imm, input logic src,
                          input logic [3:0] alu, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw);
      id_valid       = 1'b1;
      id_rs1_addr    = rs1;
      id_rs1_data    = d1;
      id_rs2_addr    = rs2;
      id_rs2_data    = d2;
      id_imm         = imm;
      id_alu_src     = src;
      id_alu_control = alu;
      id_rd_addr     = rd;
      id_reg_write   = rw;
      id_mem_read    = mr;
      id_mem_write   = mw;
   endtask

   task automatic clear_fwd();
      exm_rd = '0; exm_reg_write = 1'b0; exm_result = '0;
      mwb_rd = '0; mwb_reg_write = 1'b0; mwb_data = '0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      flush = 1'b0;
      ex_ready = 1'b1;
      present(5'd0, '0, 5'd0, '0, '0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      id_valid = 1'b0;
      clear_fwd();
      #1;
      chk("rst_valid", 32'(ex_valid), 32'd0);
      chk("rst_ready", 32'(id_ready), 32'd1);
      chk("rst_in1", ex_in1, 32'd0);
      chk("rst_in2", ex_in2, 32'd0);
      chk("rst_alu", 32'(ex_alu_control), 32'd0);
      chk("rst_rw", 32'(ex_reg_write), 32'd0);
      tick();
      rst_n = 1'b1;

      // basic pass-through
      present(5'd1, 32'd23, 5'd2, 32'd42, 32'd0, 1'b0, 4'b0010, 5'd4, 1'b1, 1'b0, 1'b0);
      tick();
      id_valid = 1'b0;
      #1;
      chk("basic_valid", 32'(ex_valid), 32'd1);
      chk("basic_in1", ex_in1, 32'd23);
      chk("basic_in2", ex_in2, 32'd42);
      chk("basic_alu", 32'(ex_alu_control), 32'b0010);
      chk("basic_rd", 32'(ex_rd_addr), 32'd4);
      chk("basic_rw", 32'(ex_reg_write), 32'd1);
      chk("basic_sd", ex_store_data, 32'd42);

      // forwarding priority
      present(5'd5, 32'd23, 5'd2, 32'd42, 32'd0, 1'b0, 4'b0010, 5'd4, 1'b1, 1'b0, 1'b0);
      tick();
      id_valid = 1'b0;
      exm_rd = 5'd5; exm_reg_write = 1'b1; exm_result = 32'd100;
      mwb_rd = 5'd5; mwb_reg_write = 1'b1; mwb_data = 32'd7;
      #1;
      chk("fwd_exm", ex_in1, 32'd100);
      exm_rd = 5'd0;
      #1;
      chk("fwd_mwb", ex_in1, 32'd7);
      mwb_reg_write = 1'b0;
      #1;
      chk("fwd_none", ex_in1, 32'd23);
      clear_fwd();

      // load-use bubble
      present(5'd1, 32'd50, 5'd0, 32'd0, 32'd0, 1'b1, 4'b0000, 5'd3, 1'b1, 1'b1, 1'b0);
      tick();
      present(5'd6, 32'd11, 5'd3, 32'd0, 32'd0, 1'b0, 4'b0000, 5'd8, 1'b1, 1'b0, 1'b0);
      #1;
      chk("lu_ready", 32'(id_ready), 32'd0);
      chk("lu_load_mr", 32'(ex_mem_read), 32'd1);
      tick();
      #1;
      chk("lu_bubble", 32'(ex_valid), 32'd0);
      chk("lu_bubble_mr", 32'(ex_mem_read), 32'd0);
      chk("lu_ready2", 32'(id_ready), 32'd1);
      tick();
      id_valid = 1'b0;
      mwb_rd = 5'd3; mwb_reg_write = 1'b1; mwb_data = 32'h1234;
      #1;
      chk("lu_dep_valid", 32'(ex_valid), 32'd1);
      chk("lu_dep_rd", 32'(ex_rd_addr), 32'd8);
      chk("lu_dep_in1", ex_in1, 32'd11);
      chk("lu_dep_in2", ex_in2, 32'h1234);
      clear_fwd();

      // stall with single-cycle forward
      present(5'd7, 32'd1, 5'd2, 32'd42, 32'd0, 1'b0, 4'b0110, 5'd9, 1'b1, 1'b0, 1'b0);
      tick();
      present(5'd12, 32'd999, 5'd13, 32'd998, 32'd0, 1'b0, 4'b1111, 5'd14, 1'b1, 1'b0, 1'b0);
      ex_ready = 1'b0;
      exm_rd = 5'd7; exm_reg_write = 1'b1; exm_result = 32'd55;
      #1;
      chk("hold_in1_c1", ex_in1, 32'd55);
      chk("hold_ready", 32'(id_ready), 32'd0);
      tick();
      clear_fwd();
      #1;
      chk("hold_in1_c2", ex_in1, 32'd55);
      chk("hold_valid_c2", 32'(ex_valid), 32'd1);
      tick();
      chk("hold_in1_c3", ex_in1, 32'd55);
      chk("hold_alu_c3", 32'(ex_alu_control), 32'b0110);
      tick();
      ex_ready = 1'b1;
      id_valid = 1'b0;
      #1;
      chk("rel_in1", ex_in1, 32'd55);
      chk("rel_in2", ex_in2, 32'd42);
      chk("rel_rd", 32'(ex_rd_addr), 32'd9);
      chk("rel_valid", 32'(ex_valid), 32'd1);
      chk("rel_ready", 32'(id_ready), 32'd1);

      // flush during hold
      ex_ready = 1'b0;
      id_valid = 1'b1;
      flush = 1'b1;
      #1;
      chk("fl_ready", 32'(id_ready), 32'd0);
      tick();
      flush = 1'b0;
      id_valid = 1'b0;
      ex_ready = 1'b1;
      #1;
      chk("fl_valid", 32'(ex_valid), 32'd0);
      chk("fl_rw", 32'(ex_reg_write), 32'd0);
      chk("fl_alu_not_loaded", 32'(ex_alu_control), 32'b0110);
      tick();
      chk("fl_valid2", 32'(ex_valid), 32'd0);

      // immediate select with forwarded rs2
      present(5'd1, 32'd5, 5'd10, 32'd0, 32'hFFFF_FFFC, 1'b1, 4'b0000, 5'd11, 1'b0, 1'b0, 1'b1);
      tick();
      id_valid = 1'b0;
      mwb_rd = 5'd10; mwb_reg_write = 1'b1; mwb_data = 32'd9;
      #1;
      chk("imm_in2", ex_in2, 32'hFFFF_FFFC);
      chk("imm_sd", ex_store_data, 32'd9);
      chk("imm_mw", 32'(ex_mem_write), 32'd1);
      clear_fwd();

      // reset mid-stall
      present(5'd1, 32'd77, 5'd2, 32'd88, 32'd0, 1'b0, 4'b0011, 5'd5, 1'b1, 1'b0, 1'b0);
      tick();
      id_valid = 1'b0;
      ex_ready = 1'b0;
      #1;
      chk("rs_pre_valid", 32'(ex_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rs_valid", 32'(ex_valid), 32'd0);
      chk("rs_in1", ex_in1, 32'd0);
      chk("rs_alu", 32'(ex_alu_control), 32'd0);
      rst_n = 1'b1;
      ex_ready = 1'b1;
      tick();
      chk("rs_after", 32'(ex_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
